// File: rtl/int_issue_queue_if.sv
// Payload type and the dispatch/wakeup/issue bundle shared by the int-block
// reservation station and whatever drives it.
`ifndef INTDQ_DISP_WID
`define INTDQ_DISP_WID 2
`endif

package int_issue_queue_pkg;
  localparam int PREG_W = 7;

  typedef struct packed {
    logic [1:0][PREG_W-1:0] iprs_idx;
    logic                   rd_wen;
    logic [PREG_W-1:0]      iprd_idx;
    logic [5:0]             robIdx;
    logic [3:0]             immBIdx;
    logic [3:0]             branchBIdx;
    logic [4:0]             micOp_type;
    logic                   use_imm;
  } intDQEntry_t;
endpackage

interface int_issue_queue_if #(
  parameter int INPORT_NUM = `INTDQ_DISP_WID,
  parameter int WAKEUP_NUM = 4,
  parameter int PREG_W     = int_issue_queue_pkg::PREG_W
);
  import int_issue_queue_pkg::*;

  logic                              i_squash_vld;
  logic                              o_stall;
  logic [INPORT_NUM-1:0]             i_enq_vld;
  intDQEntry_t [INPORT_NUM-1:0]      i_enq_info;
  logic [2*INPORT_NUM-1:0]           i_enq_prs_rdy;
  logic [WAKEUP_NUM-1:0]             i_wb_vld;
  logic [WAKEUP_NUM-1:0][PREG_W-1:0] i_wb_iprd;
  logic                              i_fu_busy;
  logic                              o_issue_vld;
  intDQEntry_t                       o_issue_info;

  modport master (
    output i_squash_vld, i_enq_vld, i_enq_info, i_enq_prs_rdy,
    output i_wb_vld, i_wb_iprd, i_fu_busy,
    input  o_stall, o_issue_vld, o_issue_info
  );

  modport slave (
    input  i_squash_vld, i_enq_vld, i_enq_info, i_enq_prs_rdy,
    input  i_wb_vld, i_wb_iprd, i_fu_busy,
    output o_stall, o_issue_vld, o_issue_info
  );
endinterface

// File: rtl/int_issue_queue.sv
// ALU reservation station: any-slot allocation, tag wakeup, and oldest-ready
// single issue chosen through an age matrix.
`ifndef INTDQ_DISP_WID
`define INTDQ_DISP_WID 2
`endif

module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int INPORT_NUM = `INTDQ_DISP_WID,
  parameter int WAKEUP_NUM = 4,
  parameter int PREG_W     = int_issue_queue_pkg::PREG_W
) (
  input  logic             clk,
  input  logic             rst,
  int_issue_queue_if.slave io
);

  // r_older[e][j] set means entry j is older than entry e
  logic [DEPTH-1:0]            r_vld, r_rdy0, r_rdy1;
  logic [DEPTH-1:0][DEPTH-1:0] r_older;
  intDQEntry_t [DEPTH-1:0]     r_info;
  logic                        r_issue_vld;
  intDQEntry_t                 r_issue_info;

  logic [DEPTH-1:0]                  w_vld_nxt, w_rdy0_nxt, w_rdy1_nxt;
  logic [DEPTH-1:0]                  w_wk0, w_wk1, w_cand, w_pick, w_row_acc;
  logic [DEPTH-1:0][DEPTH-1:0]       w_older_nxt;
  intDQEntry_t [DEPTH-1:0]           w_info_nxt;
  logic [INPORT_NUM-1:0][DEPTH-1:0]  w_alloc;
  logic [INPORT_NUM-1:0]             w_rdy0_in, w_rdy1_in;
  intDQEntry_t                       w_pick_info;
  logic                              w_do_issue, w_enq_en, w_stall, w_age_ok;
  int                                w_free_cnt, w_nth;
  logic [WAKEUP_NUM-1:0]             w_wb_vld;
  logic [WAKEUP_NUM-1:0][PREG_W-1:0] w_wb_iprd;

  function automatic logic f_wb_hit(
    input logic [PREG_W-1:0]                  tag,
    input logic [WAKEUP_NUM-1:0]              vld,
    input logic [WAKEUP_NUM-1:0][PREG_W-1:0]  iprd
  );
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKEUP_NUM; w++)
      if (vld[w] && (iprd[w] == tag) && (tag != '0)) hit = 1'b1;
    return hit;
  endfunction

  assign w_wb_vld   = io.i_wb_vld;
  assign w_wb_iprd  = io.i_wb_iprd;
  assign w_free_cnt = DEPTH - $countones(r_vld);
  assign w_stall    = w_free_cnt < INPORT_NUM;
  assign w_enq_en   = !io.i_squash_vld && !w_stall;
  assign w_cand     = r_vld & r_rdy0 & r_rdy1;
  assign w_do_issue = !io.i_fu_busy && (|w_cand);

  always_comb begin
    w_wk0 = '0;
    w_wk1 = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_wk0[e] = f_wb_hit(r_info[e].iprs_idx[0], w_wb_vld, w_wb_iprd);
      w_wk1[e] = f_wb_hit(r_info[e].iprs_idx[1], w_wb_vld, w_wb_iprd);
    end
  end

  always_comb begin
    w_pick      = '0;
    w_pick_info = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_pick[e] = w_cand[e] && !(|(r_older[e] & w_cand));
      if (w_pick[e]) w_pick_info = r_info[e];
    end
  end

  // Slots are drawn from registered free bits only, so a slot vacated by
  // this cycle's issue waits one cycle before reuse.
  always_comb begin
    w_alloc = '0;
    w_nth   = 0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!r_vld[e]) begin
        for (int k = 0; k < INPORT_NUM; k++)
          if (w_nth == k) w_alloc[k][e] = 1'b1;
        w_nth = w_nth + 1;
      end
    end
    for (int k = 0; k < INPORT_NUM; k++) begin
      w_rdy0_in[k] = io.i_enq_prs_rdy[2*k] || (io.i_enq_info[k].iprs_idx[0] == '0) ||
                     f_wb_hit(io.i_enq_info[k].iprs_idx[0], w_wb_vld, w_wb_iprd);
      w_rdy1_in[k] = io.i_enq_prs_rdy[2*k+1] || (io.i_enq_info[k].iprs_idx[1] == '0) ||
                     f_wb_hit(io.i_enq_info[k].iprs_idx[1], w_wb_vld, w_wb_iprd);
    end
  end

  always_comb begin
    w_vld_nxt   = r_vld;
    w_rdy0_nxt  = r_rdy0 | (r_vld & w_wk0);
    w_rdy1_nxt  = r_rdy1 | (r_vld & w_wk1);
    w_older_nxt = r_older;
    w_info_nxt  = r_info;
    for (int e = 0; e < DEPTH; e++) begin
      if (w_do_issue && w_pick[e]) begin
        w_vld_nxt[e]   = 1'b0;
        w_rdy0_nxt[e]  = 1'b0;
        w_rdy1_nxt[e]  = 1'b0;
        w_older_nxt[e] = '0;
        for (int j = 0; j < DEPTH; j++) w_older_nxt[j][e] = 1'b0;
      end
    end
    // Survivors plus lower-port beats of this cycle are all older than a new entry.
    w_row_acc = w_vld_nxt;
    for (int k = 0; k < INPORT_NUM; k++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_enq_en && io.i_enq_vld[k] && w_alloc[k][e]) begin
          w_vld_nxt[e]  = 1'b1;
          w_rdy0_nxt[e] = w_rdy0_in[k];
          w_rdy1_nxt[e] = w_rdy1_in[k];
          w_info_nxt[e] = io.i_enq_info[k];
          for (int j = 0; j < DEPTH; j++) w_older_nxt[j][e] = 1'b0;
          w_older_nxt[e] = w_row_acc;
        end
      end
      if (w_enq_en && io.i_enq_vld[k]) w_row_acc = w_row_acc | w_alloc[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld        <= '0;
      r_rdy0       <= '0;
      r_rdy1       <= '0;
      r_older      <= '0;
      r_info       <= '0;
      r_issue_vld  <= 1'b0;
      r_issue_info <= '0;
    end else if (io.i_squash_vld) begin
      r_vld       <= '0;
      r_rdy0      <= '0;
      r_rdy1      <= '0;
      r_older     <= '0;
      r_issue_vld <= 1'b0;
    end else begin
      r_vld       <= w_vld_nxt;
      r_rdy0      <= w_rdy0_nxt;
      r_rdy1      <= w_rdy1_nxt;
      r_older     <= w_older_nxt;
      r_info      <= w_info_nxt;
      r_issue_vld <= w_do_issue;
      if (w_do_issue) r_issue_info <= w_pick_info;
    end
  end

  assign io.o_stall      = w_stall;
  assign io.o_issue_vld  = r_issue_vld;
  assign io.o_issue_info = r_issue_info;

  always_comb begin
    w_age_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if ((i != j) && r_vld[i] && r_vld[j] && (r_older[i][j] == r_older[j][i]))
          w_age_ok = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      assert ($onehot0(w_pick));
      assert (w_age_ok);
    end
  end

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- ALU reservation station for the int block; directly downstream of dispatch.
- Consumes intDQ dequeue beats and drives back the int-block stall.
- Tracks source-operand readiness via writeback tag broadcasts and issues at most one ready instruction per cycle, oldest first, to the ALU pipeline.
- Age order is kept in an age matrix so allocation can use any free slot.

Parameters:
- DEPTH, 8, number of RS entries (>= INPORT_NUM, <= 32)
- INPORT_NUM, `INTDQ_DISP_WID, enqueue beats per cycle
- WAKEUP_NUM, 4, writeback tag broadcast ports
- PREG_W, 7, physical register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- i_squash_vld  in  1  flush all entries
- o_stall  out  1  to dispatch i_intBlock_stall
- i_enq_vld  in  INPORT_NUM  enqueue beats, contiguous from bit 0
- i_enq_info  in  intDQEntry_t[INPORT_NUM]  entry payload (iprs_idx[2], rd_wen, iprd_idx, robIdx, immBIdx, branchBIdx, micOp_type, use_imm)
- i_enq_prs_rdy  in  2*INPORT_NUM  initial source readiness from busy table, {src1,src0} per port
- i_wb_vld  in  WAKEUP_NUM  tag broadcast valid
- i_wb_iprd  in  PREG_W[WAKEUP_NUM]  broadcast physical tag
- i_fu_busy  in  1  ALU cannot accept an issue next cycle
- o_issue_vld  out  1  registered issue pulse
- o_issue_info  out  intDQEntry_t  registered issued payload

Behaviour:
- Reset (rst low, async):
  - all entry valid bits, ready bits and age matrix cleared.
  - o_issue_vld=0, o_issue_info=0, o_stall=0.
- Free count:
  - free_cnt = DEPTH - popcount(valid), computed from registered state only.
  - o_stall = (free_cnt < INPORT_NUM), combinational from registers.
- Enqueue:
  - Taken on every clk edge where i_enq_vld[k]=1 and i_squash_vld=0.
  - Enqueue while o_stall=1 is a protocol error: all beats of that cycle are dropped, and the bench asserts.
  - Beat k goes to the k-th lowest-index free slot.
  - Age row/column is set so the new entry is younger than all existing entries.
  - Among same-cycle beats, a lower port is older.
- Entry freeing: a slot freed by issue this cycle is not reallocated until the next cycle.
- Source readiness:
  - src ready = i_enq_prs_rdy bit, OR iprs_idx==0, OR a same-cycle i_wb match (enqueue bypass).
  - Each valid entry compares both iprs_idx against all i_wb_iprd where i_wb_vld. A match sets the ready bit at the edge.
  - Tag 0 broadcasts are ignored.
  - Ready bits never clear except on free, squash or reset.
- Select:
  - cand[e] = valid & rdy0 & rdy1. pick = the cand with no older cand (age matrix one-hot).
  - If i_fu_busy=1 or no cand, nothing is issued and o_issue_vld=0 next cycle.
  - Otherwise, at the edge: o_issue_vld=1, o_issue_info=entry payload, and the entry's valid is cleared.
- Latency:
  - Enqueue at edge E with both sources ready -> o_issue_vld high after edge E+1.
  - A wakeup at edge E for a waiting entry -> issue at edge E+1 at the earliest.
- o_issue_vld is a one-cycle pulse per instruction with no hold; the ALU must accept whenever i_fu_busy was 0 in the selecting cycle.
- Squash:
  - Takes precedence over enqueue, wakeup and issue.
  - At the edge: all valid bits cleared, age matrix cleared, o_issue_vld=0.
  - o_stall deasserts the following cycle.
- Simultaneous issue and enqueue in the same cycle: both proceed; the age matrix clears the issued row/column and sets the new rows.
- Full: with DEPTH valid entries, o_stall=1 and no allocation. One issue alone does not drop o_stall unless free_cnt reaches INPORT_NUM.
- Invariants (asserted):
  - At most one issue per cycle.
  - The pick is onehot0.
  - Age matrix is antisymmetric over valid entries.

Test Plan:
- Reset, then enqueue 2 beats (iprs={3,0}, prs_rdy=11 and iprs={5,6}, prs_rdy=00) -> cycle after: o_issue_vld=1 with beat0's robIdx; beat1 is never issued without wakeup.
- Wakeup ordering: i_wb_vld[2]=1 tag 5 at edge E, then tag 6 at E+1 -> beat1 issues with o_issue_vld high after edge E+2, payload matches.
- Age ordering: enqueue A (not ready, tag 9), then B (ready), then wake A; both now ready in the same cycle -> A issues before B, in consecutive cycles.
- Fill DEPTH=8 with non-ready entries -> o_stall=1. An enqueue attempt is dropped and the assertion fires. Waking one entry issues it; o_stall stays 1 while free_cnt=1 < INPORT_NUM=2.
- i_fu_busy=1 for 3 cycles with 2 ready entries -> no issue during that time. Release -> issues on two consecutive cycles, oldest first.
- Squash with 5 valid entries while simultaneously enqueuing and waking -> next cycle: all empty, o_issue_vld=0, o_stall=0. A fresh enqueue after that issues normally.
- Async reset asserted mid-issue (between edges) -> o_issue_vld drops immediately, without waiting for a clock edge.
